host_mem_bridge: RTL and testbench

- Byte-stream command decoder that lets the host load, read back and run the CPU over the SPI byte link.
- Sits between `spi_slave` (byte strobe/data) and the multi-bank `ram` write/read ports, and owns the CPU reset.
- Parametrised successor of the fixed IRAM/DRAM loader:
  - NBANK memory banks instead of two.
  - Configurable address length and lane count.
  - Explicit SET_ADDR command, access protection while the CPU runs, and an error flag.

---
 rtl/host_mem_bridge.sv | 199 +++++++++++++++++++
 tb/tb_host_mem_bridge.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/host_mem_bridge.sv
// host_mem_bridge: SPI byte-stream command decoder that loads, reads back
// and runs the CPU through the multi-bank RAM write/read ports.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   dc_i                0 = command byte, 1 = data byte
//   byte_vld_i          one-cycle strobe for byte_data_i
//   byte_data_i         received byte
//   cpu_rst_n_o         CPU reset (0 = held)
//   rd_sel_o, wr_sel_o  one-hot bank selects
//   addr_o              byte address, zero-extended from 8*ADDR_BYTES bits
//   wr_data_o           received byte replicated on every lane
//   wr_byte_en_o        one-hot lane write pulse
//   err_o               one-cycle pulse on a rejected command
//   chk_o               write checksum
//
// Optional feature macro: HOST_MEM_BRIDGE_CHECKSUM_EN
//   defined   : chk_o is the 8-bit sum of bytes written since the last WRITE
//   undefined : chk_o is tied to zero
module host_mem_bridge #(
    parameter int XLEN       = 32,
    parameter int NBANK      = 2,
    parameter int ADDR_BYTES = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              dc_i,
    input  logic              byte_vld_i,
    input  logic [7:0]        byte_data_i,
    output logic              cpu_rst_n_o,
    output logic [NBANK-1:0]  rd_sel_o,
    output logic [NBANK-1:0]  wr_sel_o,
    output logic [XLEN-1:0]   addr_o,
    output logic [XLEN-1:0]   wr_data_o,
    output logic [XLEN/8-1:0] wr_byte_en_o,
    output logic              err_o,
    output logic [7:0]        chk_o
);

    localparam int LANES = XLEN / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW    = 8 * ADDR_BYTES;
    localparam int CW    = $clog2(ADDR_BYTES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RD   = 2'd3;

    localparam logic [3:0] OP_HOLD  = 4'h1;
    localparam logic [3:0] OP_RUN   = 4'h2;
    localparam logic [3:0] OP_SETA  = 4'h3;
    localparam logic [3:0] OP_WRITE = 4'h4;
    localparam logic [3:0] OP_READ  = 4'h5;

    logic [1:0]       state;
    logic [AW-1:0]    addr;
    logic [AW-1:0]    abuf;
    logic [AW-1:0]    abuf_nxt;
    logic [AW-1:0]    addr_inc;
    logic [AW-1:0]    wr_addr;
    logic [CW-1:0]    cnt;
    logic             pend;
    logic             cmd;
    logic             dat;
    logic [3:0]       op;
    logic [3:0]       bank;
    logic             bank_ok;
    logic [NBANK-1:0] bank_oh;
    logic             wr_ok;
    logic             rd_ok;

    function automatic logic [LANES-1:0] lane_oh(input logic [AW-1:0] a);
        logic [LANES-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            if (LANES == 1 || int'(a[LW-1:0]) == i) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    always_comb begin
        cmd      = byte_vld_i & ~dc_i;
        dat      = byte_vld_i & dc_i;
        op       = byte_data_i[7:4];
        bank     = byte_data_i[3:0];
        bank_ok  = int'(bank) < NBANK;
        bank_oh  = '0;
        for (int i = 0; i < NBANK; i++) begin
            bank_oh[i] = (bank == 4'(i));
        end
        // Memory access is only granted while the CPU is held.
        wr_ok    = (op == OP_WRITE) && bank_ok && !cpu_rst_n_o;
        rd_ok    = (op == OP_READ) && bank_ok && !cpu_rst_n_o;
        addr_inc = addr + AW'(1);
        // A write pulse issued last cycle still owes its increment.
        wr_addr  = pend ? addr_inc : addr;
        abuf_nxt = abuf;
        if (int'(cnt) < ADDR_BYTES) begin
            abuf_nxt[8*int'(cnt) +: 8] = byte_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= ST_IDLE;
            addr         <= '0;
            abuf         <= '0;
            cnt          <= '0;
            pend         <= 1'b0;
            cpu_rst_n_o  <= 1'b0;
            rd_sel_o     <= '0;
            wr_sel_o     <= '0;
            wr_data_o    <= '0;
            wr_byte_en_o <= '0;
            err_o        <= 1'b0;
        end else begin
            err_o        <= 1'b0;
            wr_byte_en_o <= '0;
            if (cmd) begin
                if (pend) begin
                    addr <= addr_inc;
                end
                pend     <= 1'b0;
                cnt      <= '0;
                rd_sel_o <= '0;
                wr_sel_o <= '0;
                state    <= ST_IDLE;
                case (op)
                    OP_HOLD: cpu_rst_n_o <= 1'b0;
                    OP_RUN:  cpu_rst_n_o <= 1'b1;
                    OP_SETA: state <= ST_ADDR;
                    OP_WRITE: begin
                        if (wr_ok) begin
                            wr_sel_o <= bank_oh;
                            state    <= ST_WR;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    OP_READ: begin
                        if (rd_ok) begin
                            rd_sel_o <= bank_oh;
                            state    <= ST_RD;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                    default: err_o <= 1'b1;
                endcase
            end else if (dat) begin
                case (state)
                    ST_ADDR: begin
                        abuf <= abuf_nxt;
                        cnt  <= cnt + CW'(1);
                        if (int'(cnt) == ADDR_BYTES - 1) begin
                            addr  <= abuf_nxt;
                            state <= ST_IDLE;
                        end
                    end
                    ST_WR: begin
                        addr         <= wr_addr;
                        wr_byte_en_o <= lane_oh(wr_addr);
                        wr_data_o    <= {LANES{byte_data_i}};
                        pend         <= 1'b1;
                    end
                    ST_RD: addr <= addr_inc;
                    default: ;
                endcase
            end else if (pend) begin
                addr <= addr_inc;
                pend <= 1'b0;
            end
        end
    end

    assign addr_o = XLEN'(addr);

`ifdef HOST_MEM_BRIDGE_CHECKSUM_EN
    logic [7:0] chk;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            chk <= 8'h00;
        end else if (cmd && wr_ok) begin
            chk <= 8'h00;
        end else if (dat && state == ST_WR) begin
            chk <= chk + byte_data_i;
        end
    end

    assign chk_o = chk;
`else
    assign chk_o = 8'h00;
`endif

endmodule

// File: tb/tb_host_mem_bridge.sv
// tb_host_mem_bridge: directed self-checking bench for host_mem_bridge
// (XLEN=32, NBANK=2, ADDR_BYTES=3).
module tb_host_mem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dc = 1'b0;
    logic        byte_vld = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        cpu_rst_n;
    logic [1:0]  rd_sel;
    logic [1:0]  wr_sel;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byte_en;
    logic        err;
    logic [7:0]  chk;

    int checks = 0;
    int errors = 0;

    host_mem_bridge #(
        .XLEN(32),
        .NBANK(2),
        .ADDR_BYTES(3)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .dc_i(dc),
        .byte_vld_i(byte_vld),
        .byte_data_i(byte_data),
        .cpu_rst_n_o(cpu_rst_n),
        .rd_sel_o(rd_sel),
        .wr_sel_o(wr_sel),
        .addr_o(addr),
        .wr_data_o(wr_data),
        .wr_byte_en_o(wr_byte_en),
        .err_o(err),
        .chk_o(chk)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; strobe is sampled by the next posedge and
    // the task returns at the following negedge (N+1 view).
    task automatic strobe(input logic d, input logic [7:0] b);
        dc        = d;
        byte_data = b;
        byte_vld  = 1'b1;
        @(negedge clk);
        byte_vld  = 1'b0;
        dc        = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".cpu"}, 32'(cpu_rst_n), 32'd0);
        check({tag, ".rsel"}, 32'(rd_sel), 32'd0);
        check({tag, ".wsel"}, 32'(wr_sel), 32'd0);
        check({tag, ".addr"}, addr, 32'd0);
        check({tag, ".wdat"}, wr_data, 32'd0);
        check({tag, ".ben"}, 32'(wr_byte_en), 32'd0);
        check({tag, ".err"}, 32'(err), 32'd0);
        check({tag, ".chk"}, 32'(chk), 32'd0);
    endtask

    logic [7:0]  wbytes [4];
    logic [3:0]  wben   [4];
    logic [7:0]  exp_chk;

    initial begin
        wbytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wben   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        check_reset("rst");

        // Load at 0x10 and burst four back-to-back bytes into bank 0.
        strobe(1'b0, 8'h10);
        strobe(1'b0, 8'h30);
        strobe(1'b1, 8'h10);
        strobe(1'b1, 8'h00);
        strobe(1'b1, 8'h00);
        check("seta.addr", addr, 32'h10);
        strobe(1'b0, 8'h40);
        check("wr.wsel", 32'(wr_sel), 32'h1);
        check("wr.rsel", 32'(rd_sel), 32'h0);
        for (int i = 0; i < 4; i++) begin
            strobe(1'b1, wbytes[i]);
            check($sformatf("wr.ben%0d", i), 32'(wr_byte_en), 32'(wben[i]));
            check($sformatf("wr.addr%0d", i), addr, 32'h10 + 32'(i));
            check($sformatf("wr.data%0d", i), wr_data, {4{wbytes[i]}});
        end
        idle();
        check("wr.ben_end", 32'(wr_byte_en), 32'h0);
        check("wr.addr_end", addr, 32'h14);
`ifdef HOST_MEM_BRIDGE_CHECKSUM_EN
        exp_chk = 8'h0E;
`else
        exp_chk = 8'h00;
`endif
        check("wr.chk", 32'(chk), 32'(exp_chk));

        // Address wrap at the top of the 24-bit space, bank 1.
        strobe(1'b0, 8'h30);
        strobe(1'b1, 8'hFF);
        strobe(1'b1, 8'hFF);
        strobe(1'b1, 8'hFF);
        check("wrap.addr", addr, 32'hFFFFFF);
        strobe(1'b0, 8'h41);
        check("wrap.wsel", 32'(wr_sel), 32'h2);
        strobe(1'b1, 8'h55);
        check("wrap.addr_w", addr, 32'hFFFFFF);
        check("wrap.ben", 32'(wr_byte_en), 32'h8);
        check("wrap.data", wr_data, 32'h55555555);
        idle();
        check("wrap.addr0", addr, 32'h0);
`ifdef HOST_MEM_BRIDGE_CHECKSUM_EN
        exp_chk = 8'h55;
`else
        exp_chk = 8'h00;
`endif
        check("wrap.chk", 32'(chk), 32'(exp_chk));

        // WRITE while running is rejected.
        strobe(1'b0, 8'h20);
        check("run.cpu", 32'(cpu_rst_n), 32'h1);
        check("run.wsel", 32'(wr_sel), 32'h0);
        strobe(1'b0, 8'h40);
        check("run.err", 32'(err), 32'h1);
        check("run.wsel2", 32'(wr_sel), 32'h0);
        check("run.cpu2", 32'(cpu_rst_n), 32'h1);
        idle();
        check("run.err_clr", 32'(err), 32'h0);
        strobe(1'b1, 8'h12);
        check("run.ben", 32'(wr_byte_en), 32'h0);
        check("run.addr", addr, 32'h0);

        // READ to missing bank, then a valid read burst from 0x20.
        strobe(1'b0, 8'h10);
        check("hold.cpu", 32'(cpu_rst_n), 32'h0);
        strobe(1'b0, 8'h57);
        check("rdbad.err", 32'(err), 32'h1);
        check("rdbad.rsel", 32'(rd_sel), 32'h0);
        strobe(1'b0, 8'h30);
        strobe(1'b1, 8'h20);
        strobe(1'b1, 8'h00);
        strobe(1'b1, 8'h00);
        strobe(1'b0, 8'h50);
        check("rd.rsel", 32'(rd_sel), 32'h1);
        check("rd.err", 32'(err), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            strobe(1'b1, 8'h00);
            check($sformatf("rd.addr%0d", i), addr, 32'h20 + 32'(i));
        end

        // Unknown opcode.
        strobe(1'b0, 8'hF0);
        check("bad.err", 32'(err), 32'h1);
        check("bad.rsel", 32'(rd_sel), 32'h0);

        // Aborted SET_ADDR keeps the old address.
        strobe(1'b0, 8'h30);
        strobe(1'b1, 8'h34);
        strobe(1'b0, 8'h20);
        check("abort.addr", addr, 32'h23);
        check("abort.cpu", 32'(cpu_rst_n), 32'h1);
        strobe(1'b1, 8'h56);
        check("abort.addr2", addr, 32'h23);

        // Asynchronous reset in the middle of a write burst.
        strobe(1'b0, 8'h10);
        strobe(1'b0, 8'h41);
        strobe(1'b1, 8'h77);
        check("mid.ben", 32'(wr_byte_en), 32'h8);
        #2 rst_n = 1'b0;
        #1;
        check_reset("async");
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check_reset("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
